// File: rtl/cordic_arb_pkg.sv
// Shared types and defaults for the CORDIC share arbiter.
// Holds the FSM state type, the default operand width and iteration count, and a
// helper that sizes requester index signals. The helper returns at least 1 so that
// a single-requester build still has legal vector widths.
package cordic_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StIter,
      StResp
   } state_e;

   localparam int unsigned DefDw   = 16;
   localparam int unsigned DefIter = 16;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Scans the request vector starting at lane ptr and wrapping, and reports the first
// lane found.
// Ports:
//   req        requests, one bit per lane
//   ptr        lane with the highest priority this cycle
//   winner     one-hot winning lane (all zero when found is low)
//   winner_idx binary index of the winning lane
//   found      at least one request is pending
module rr_pick
   import cordic_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] winner,
   output logic [PW-1:0]   winner_idx,
   output logic            found
);

   always_comb begin
      int unsigned k;
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      k          = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = (32'(ptr) + i) % NREQ;
         if (!found && ((req & (NREQ'(1) << k)) != '0)) begin
            found      = 1'b1;
            winner     = NREQ'(1) << k;
            winner_idx = PW'(k);
         end
      end
   end

endmodule

// File: rtl/cordic_share_arbiter.sv
// Round-robin arbiter that time-shares one iterative CORDIC unit between NREQ
// requesters.
// Each operation runs LOAD (grant pulse, operands registered, cu_start),
// then ITER micro-rotations, then RESP (result pulse to the owner). RESP arbitrates
// directly into the next LOAD, so back-to-back operations take ITER+2 cycles.
// Optional feature: define CORDIC_ARB_LOCK_EN to add the lock port. When lock[w] is
// high during RESP, the round-robin pointer stays on w so that lane can chain
// operations.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   req               per-lane operation request, held until gnt
//   lock              per-lane ownership retention (CORDIC_ARB_LOCK_EN only)
//   op_x, op_z        packed operands, lane k at [k*DW +: DW]
//   gnt               one-hot grant pulse (LOAD)
//   rsp_valid         one-hot result pulse (RESP)
//   rsp_data          result for the owner, held until the next result
//   cu_start          load pulse to the CORDIC unit
//   cu_x, cu_z        registered operands to the CORDIC unit
//   cu_en, cu_iter    micro-rotation enable and index
//   cu_y              CORDIC unit result
//   busy              high whenever the FSM is not idle
module cordic_share_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = DefDw,
   parameter int unsigned ITER = DefIter,
   parameter int unsigned IW   = $clog2(ITER)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
`ifdef CORDIC_ARB_LOCK_EN
   input  logic [NREQ-1:0]      lock,
`endif
   input  logic [NREQ*DW-1:0]   op_x,
   input  logic [NREQ*DW-1:0]   op_z,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DW-1:0]        rsp_data,
   output logic                 cu_start,
   output logic [DW-1:0]        cu_x,
   output logic [DW-1:0]        cu_z,
   output logic                 cu_en,
   output logic [IW-1:0]        cu_iter,
   input  logic [DW-1:0]        cu_y,
   output logic                 busy
);

   localparam int unsigned PW = idx_width(NREQ);

   state_e          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   w_idx;
   logic [NREQ-1:0] w_oh;

   logic [NREQ-1:0] lock_eff;
   logic [PW-1:0]   resp_ptr;
   logic [PW-1:0]   ptr_eff;
   logic [NREQ-1:0] pick_oh;
   logic [PW-1:0]   pick_idx;
   logic            pick_found;
   logic [DW-1:0]   pick_x;
   logic [DW-1:0]   pick_z;

`ifdef CORDIC_ARB_LOCK_EN
   assign lock_eff = lock;
`else
   assign lock_eff = '0;
`endif

   // The pointer update for the finishing operation must already apply to the
   // arbitration done in RESP, otherwise the same lane would win twice in a row.
   always_comb begin
      resp_ptr = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
      if ((lock_eff & w_oh) != '0) begin
         resp_ptr = w_idx;
      end
      ptr_eff = (state == StResp) ? resp_ptr : ptr;
   end

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req        (req),
      .ptr        (ptr_eff),
      .winner     (pick_oh),
      .winner_idx (pick_idx),
      .found      (pick_found)
   );

   assign pick_x = DW'(op_x >> (32'(pick_idx) * DW));
   assign pick_z = DW'(op_z >> (32'(pick_idx) * DW));

   assign busy = (state != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         ptr       <= '0;
         w_idx     <= '0;
         w_oh      <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         cu_start  <= 1'b0;
         cu_x      <= '0;
         cu_z      <= '0;
         cu_en     <= 1'b0;
         cu_iter   <= '0;
      end else begin
         // Pulse outputs default low; only their owning transition raises them.
         gnt       <= '0;
         rsp_valid <= '0;
         cu_start  <= 1'b0;
         unique case (state)
            StIdle, StResp: begin
               if (state == StResp) begin
                  ptr <= resp_ptr;
               end
               if (pick_found) begin
                  state    <= StLoad;
                  gnt      <= pick_oh;
                  cu_start <= 1'b1;
                  w_oh     <= pick_oh;
                  w_idx    <= pick_idx;
                  cu_x     <= pick_x;
                  cu_z     <= pick_z;
               end else begin
                  state <= StIdle;
               end
            end
            StLoad: begin
               state   <= StIter;
               cu_en   <= 1'b1;
               cu_iter <= '0;
            end
            StIter: begin
               if (cu_iter == IW'(ITER - 1)) begin
                  state     <= StResp;
                  cu_en     <= 1'b0;
                  cu_iter   <= '0;
                  rsp_valid <= w_oh;
                  rsp_data  <= cu_y;
               end else begin
                  cu_iter <= cu_iter + IW'(1);
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Self-checking bench for cordic_share_arbiter (NREQ=4, DW=16, ITER=16).
// The CORDIC unit is stood in for by cu_y = cu_x + cu_z + cu_iter, so the
// expected result of an operation on (x, z) is x + z + 15.
module tb_cordic_share_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 16;
   localparam int unsigned ITER = 16;
   localparam int unsigned IW   = 4;

`ifdef CORDIC_ARB_LOCK_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic [NREQ-1:0]      req = '0;
`ifdef CORDIC_ARB_LOCK_EN
   logic [NREQ-1:0]      lock = '0;
`endif
   logic [NREQ*DW-1:0]   op_x = '0;
   logic [NREQ*DW-1:0]   op_z = '0;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      rsp_valid;
   logic [DW-1:0]        rsp_data;
   logic                 cu_start;
   logic [DW-1:0]        cu_x;
   logic [DW-1:0]        cu_z;
   logic                 cu_en;
   logic [IW-1:0]        cu_iter;
   logic [DW-1:0]        cu_y;
   logic                 busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign cu_y = cu_x + cu_z + DW'(cu_iter);

   cordic_share_arbiter #(
      .NREQ (NREQ),
      .DW   (DW),
      .ITER (ITER),
      .IW   (IW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
`ifdef CORDIC_ARB_LOCK_EN
      .lock      (lock),
`endif
      .op_x      (op_x),
      .op_z      (op_z),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .cu_start  (cu_start),
      .cu_x      (cu_x),
      .cu_z      (cu_z),
      .cu_en     (cu_en),
      .cu_iter   (cu_iter),
      .cu_y      (cu_y),
      .busy      (busy)
   );

   typedef struct {
      logic [NREQ-1:0] req;
      int              win;
      logic [DW-1:0]   x;
      logic [DW-1:0]   z;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int oh2idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < int'(NREQ); i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] z);
      return x + z + DW'(ITER - 1);
   endfunction

   // Winner lane gets (x, z); other lanes get distinct filler values.
   task automatic set_ops(input int win, input logic [DW-1:0] x, input logic [DW-1:0] z);
      for (int k = 0; k < int'(NREQ); k++) begin
         op_x[k*DW +: DW] = (k == win) ? x : DW'(16'hD000 + k);
         op_z[k*DW +: DW] = (k == win) ? z : DW'(16'hE000 + k);
      end
   endtask

   task automatic set_lane_ops();
      for (int k = 0; k < int'(NREQ); k++) begin
         op_x[k*DW +: DW] = DW'(16'h1000 * k + 1);
         op_z[k*DW +: DW] = DW'(16'h0100 * k + 2);
      end
   endtask

   task automatic wait_gnt(input int max, output int lane, output int t);
      int n;
      n = 0;
      lane = -1;
      t = 0;
      do begin
         tick();
         n++;
      end while (gnt == '0 && n < max);
      if (gnt != '0) begin
         lane = oh2idx(gnt);
         t = cyc;
         check("gnt_onehot", 64'($onehot(gnt)), 64'd1);
      end else begin
         checks++;
         failures++;
         $display("FAIL gnt_timeout actual=none required=grant within %0d cycles", max);
      end
   endtask

   task automatic wait_rsp(input int max, output int lane, output int t);
      int n;
      n = 0;
      lane = -1;
      t = 0;
      do begin
         tick();
         n++;
      end while (rsp_valid == '0 && n < max);
      if (rsp_valid != '0) begin
         lane = oh2idx(rsp_valid);
         t = cyc;
         check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
      end else begin
         checks++;
         failures++;
         $display("FAIL rsp_timeout actual=none required=rsp_valid within %0d cycles", max);
      end
   endtask

   initial begin
      int lane, tg, tr, tapp, tprev, cnt, lane_exp;
      logic [DW-1:0] exp;

      vecs[0] = '{4'b0010, 1, 16'h2000, 16'h1000};
      vecs[1] = '{4'b0001, 0, 16'h1234, 16'h0F0F};
      vecs[2] = '{4'b1001, 3, 16'h8000, 16'h8000};
      vecs[3] = '{4'b0110, 1, 16'hFFF0, 16'h0000};
      vecs[4] = '{4'b0011, 0, 16'hABCD, 16'h1111};
      vecs[5] = '{4'b1000, 3, 16'h0100, 16'h0200};

      // Reset state, checked while rst_n is low.
      #1 rst_n = 1'b0;
      #2;
      check("reset_outputs", {gnt, rsp_valid, cu_start, cu_en, busy, cu_iter, cu_x, cu_z, rsp_data},
            64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_after_reset", {busy, gnt, cu_en}, 64'd0);

      // Single-request vectors from IDLE; pointer advances as the table assumes.
      for (int i = 0; i < 6; i++) begin
         set_ops(vecs[i].win, vecs[i].x, vecs[i].z);
         req = vecs[i].req;
         tapp = cyc;
         exp = model(vecs[i].x, vecs[i].z);
         wait_gnt(4, lane, tg);
         check($sformatf("v%0d_gnt_lane", i), 64'(lane), 64'(vecs[i].win));
         check($sformatf("v%0d_gnt_lat", i), 64'(tg - tapp), 64'd1);
         check($sformatf("v%0d_load", i), {cu_start, cu_x, cu_z}, {1'b1, vecs[i].x, vecs[i].z});
         req = '0;
         tick();
         check($sformatf("v%0d_iter0", i), {gnt, cu_start, cu_en, cu_iter}, {4'b0, 1'b0, 1'b1, 4'd0});
         wait_rsp(30, lane, tr);
         check($sformatf("v%0d_rsp_lane", i), 64'(lane), 64'(vecs[i].win));
         check($sformatf("v%0d_rsp_lat", i), 64'(tr - tg), 64'(ITER + 1));
         check($sformatf("v%0d_rsp_data", i), 64'(rsp_data), 64'(exp));
         tick();
         check($sformatf("v%0d_idle", i), {busy, rsp_valid, cu_en}, 64'd0);
         tick();
         tick();
         check($sformatf("v%0d_hold", i), 64'(rsp_data), 64'(exp));
      end

      // All lanes requesting continuously from ptr=0.
      set_lane_ops();
      req = 4'b1111;
      tprev = 0;
      for (int i = 0; i < 5; i++) begin
         wait_gnt(25, lane, tg);
         check($sformatf("all_lane%0d", i), 64'(lane), 64'(i % 4));
         check($sformatf("all_cu_x%0d", i), 64'(cu_x), 64'(16'h1000 * (i % 4) + 1));
         if (i > 0) check($sformatf("all_gap%0d", i), 64'(tg - tprev), 64'(ITER + 2));
         tprev = tg;
      end
      req = '0;
      wait_rsp(30, lane, tr);
      check("all_last_rsp", {32'(lane), 16'(tr - tprev), rsp_data},
            {32'd0, 16'(ITER + 1), model(16'h0001, 16'h0002)});
      tick();
      check("all_idle", 64'(busy), 64'd0);

      // Early drop: lane 2 drops req after its grant and is still answered.
      req = 4'b0101;
      wait_gnt(4, lane, tg);
      check("drop_gnt_lane", 64'(lane), 64'd2);
      tick();
      req = 4'b0001;
      wait_rsp(30, lane, tr);
      check("drop_rsp", {32'(lane), 32'(tr - tg)}, {32'd2, 32'(ITER + 1)});
      check("drop_rsp_data", 64'(rsp_data), 64'(model(16'h2001, 16'h0202)));
      wait_gnt(4, lane, tprev);
      check("drop_next", {32'(lane), 32'(tprev - tg)}, {32'd0, 32'(ITER + 2)});
      req = '0;
      wait_rsp(30, lane, tr);
      tick();
      check("drop_idle", 64'(busy), 64'd0);

      // Reset abort at cu_iter=7: ptr is 1 here, so lane 1 wins first.
      req = 4'b0010;
      wait_gnt(4, lane, tg);
      check("abort_gnt_lane", 64'(lane), 64'd1);
      req = '0;
      cnt = 0;
      while (!(cu_en && cu_iter == 4'd7) && cnt < 20) begin
         tick();
         cnt++;
      end
      check("abort_reach_iter7", {cu_en, cu_iter}, {1'b1, 4'd7});
      #2 rst_n = 1'b0;
      #1;
      check("abort_outputs", {gnt, rsp_valid, cu_start, cu_en, busy, cu_iter, cu_x, cu_z, rsp_data},
            64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rsp_valid != '0 || busy) cnt++;
      end
      check("abort_no_rsp", 64'(cnt), 64'd0);

      // Grant order after reset, with lane 0 locked for one extra operation.
      set_lane_ops();
`ifdef CORDIC_ARB_LOCK_EN
      lock = 4'b0001;
`endif
      req = 4'b0011;
      wait_gnt(4, lane, tg);
      check("post_reset_lane0", 64'(lane), 64'd0);
      wait_gnt(25, lane, tprev);
      lane_exp = LockEn ? 0 : 1;
      check("lock_second", {32'(lane), 32'(tprev - tg)}, {32'(lane_exp), 32'(ITER + 2)});
`ifdef CORDIC_ARB_LOCK_EN
      lock = '0;
`endif
      wait_gnt(25, lane, tg);
      lane_exp = LockEn ? 1 : 0;
      check("lock_third", 64'(lane), 64'(lane_exp));
      req = '0;
      wait_rsp(30, lane, tr);
      check("lock_rsp", {32'(lane), 16'(tr - tg), rsp_data},
            {32'(lane_exp), 16'(ITER + 1),
             (lane_exp == 1) ? model(16'h1001, 16'h0102) : model(16'h0001, 16'h0002)});
      tick();
      check("final_idle", {busy, gnt, rsp_valid}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cordic_share_arbiter.md
CORDIC_SHARE_ARBITER -- requirements
Module: cordic_share_arbiter

Interface
- REQ-001 Parameters SHALL be, one per line:
  - NREQ, default 4: number of requesters.
  - DW, default 16: operand and result width.
  - ITER, default 16: CORDIC micro-rotations per operation.
  - IW, default $clog2(ITER): width of the iteration index.
- REQ-002 Ports SHALL be, one per line:
  - clk  input  1  sole clock; rising edge active.
  - rst_n  input  1  asynchronous active-low reset.
  - req  input  NREQ  per-requester operation request.
  - lock  input  NREQ  per-requester ownership retention; present only with CORDIC_ARB_LOCK_EN.
  - op_x  input  NREQ*DW  packed x operands; lane k at bits [k*DW +: DW].
  - op_z  input  NREQ*DW  packed z (angle) operands; same packing.
  - gnt  output  NREQ  one-hot grant pulse.
  - rsp_valid  output  NREQ  one-hot result-valid pulse.
  - rsp_data  output  DW  result to the owner.
  - cu_start  output  1  load pulse to the shared CORDIC unit.
  - cu_x  output  DW  registered x operand to the unit.
  - cu_z  output  DW  registered z operand to the unit.
  - cu_en  output  1  micro-rotation enable.
  - cu_iter  output  IW  current micro-rotation index.
  - cu_y  input  DW  unit result; valid after the last rotation.
  - busy  output  1  high in every state except IDLE.
- REQ-003 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
- REQ-004 FSM states SHALL be IDLE, LOAD, ITER and RESP.
- REQ-005 In IDLE or RESP with any req bit high, the block SHALL pick a winner w by round-robin starting at pointer ptr and enter LOAD on the next edge.
- REQ-006 In LOAD, gnt[w] SHALL be high for exactly one cycle; op_x/op_z lane w SHALL be registered onto cu_x/cu_z; cu_start SHALL be 1 for that cycle.
- REQ-007 In ITER, cu_en SHALL be 1 and cu_iter SHALL count 0..ITER-1, one step per cycle; at ITER-1 the FSM SHALL go to RESP.
- REQ-008 In RESP, rsp_valid[w] SHALL be 1 for one cycle and rsp_data SHALL equal cu_y sampled at the final ITER edge; ptr SHALL become (w+1) mod NREQ.
- REQ-009 Latency SHALL be fixed: rsp_valid at gnt cycle + ITER + 1; throughput SHALL be one operation per ITER+2 cycles under continuous requests, since RESP arbitrates directly into LOAD.
- REQ-010 Requesters SHALL hold req until gnt; req deasserting after gnt SHALL NOT abort service, and rsp_valid SHALL still be issued.
- REQ-011 If no req is high in RESP, the FSM SHALL return to IDLE; rsp_data SHALL hold its last value.
- REQ-012 gnt, rsp_valid and cu_start SHALL never be high outside LOAD and RESP respectively, and SHALL never have more than one bit set.
- REQ-013 With NREQ=1, arbitration SHALL degenerate to lane 0 with identical timing.

Reset
- REQ-014 rst_n low SHALL immediately force all of the following: FSM=IDLE; ptr=0; gnt, rsp_valid, cu_start, cu_en, busy = 0; cu_iter, cu_x, cu_z, rsp_data = 0.
- REQ-015 Reset mid-operation SHALL abort the operation with no rsp_valid issued; arbitration SHALL resume from lane 0 after release.

Configuration
- REQ-016 Macro CORDIC_ARB_LOCK_EN defined: if lock[w] is high in RESP, ptr SHALL stay at w, so w re-wins when req[w] is still high; used for chained accumulations.
- REQ-017 CORDIC_ARB_LOCK_EN undefined: the lock port SHALL be absent and behaviour SHALL equal lock=0.

Structure
- REQ-018 Package cordic_arb_pkg SHALL hold the FSM state typedef and the default DW/ITER constants.
- REQ-019 Sub-module rr_pick SHALL implement combinational round-robin selection (req, ptr -> one-hot winner plus index).

Verification
- REQ-020 Single request: req=4'b0010, op_x=0x2000, op_z=0x1000, ITER=16 -> gnt[1] at cycle 1, rsp_valid[1] at cycle 18, rsp_data=cu_y.
- REQ-021 All request: req=4'b1111 held from ptr=0 -> grant order 0,1,2,3,0, with gnts 18 cycles apart.
- REQ-022 Early drop: req[2] dropped the cycle after gnt[2] -> rsp_valid[2] still at gnt+17; next grant goes to another pending lane.
- REQ-023 Reset abort: rst_n pulsed low at cu_iter=7 -> all outputs 0 within the reset, no rsp_valid, next grant starts at lane 0.
- REQ-024 Lock (macro on): lock[0]=1, req=4'b0011 -> lane 0 granted twice consecutively; with lock[0]=0 -> lane 1 granted next.
- REQ-025 Idle gap: req=0 in RESP -> FSM returns to IDLE, busy=0, rsp_data held.
